// File: rtl/fpu_swap_ctrl.sv
// fpu_swap_ctrl: operand-swap sequencing for the FP add/subtract front end.
// Captures X/Y on a start pulse, orders them by magnitude (exp||frac), and
// registers the greater (DMP) and lesser (DmP) operands together with the
// alignment shift, the effective operation and the provisional sign. Results
// are held in DONE until the alignment stage acknowledges them.
// Optional build macro: FPU_SHIFT_SAT_EN clamps the shift amount to SW+2.
module fpu_swap_ctrl #(
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beg_i,
    input  logic             ack_i,
    input  logic [EW+SW:0]   Data_X_i,
    input  logic [EW+SW:0]   Data_Y_i,
    input  logic             add_subt_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic             select_o,
    output logic [EW+SW:0]   DMP_o,
    output logic [EW+SW:0]   DmP_o,
    output logic [EW-1:0]    shift_amt_o,
    output logic             real_op_o,
    output logic             sign_final_o,
    output logic             zero_o
);

    localparam int W = EW + SW;

`ifdef FPU_SHIFT_SAT_EN
    localparam logic [EW-1:0] SAT_LIM = EW'(SW + 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_SWAP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [W:0]      x_q, y_q;
    logic            op_q;
    logic            select_q;
    logic [W:0]      dmp_q, dml_q;
    logic [EW-1:0]   shift_q;
    logic            real_op_q, sign_q, zero_q;
    logic            busy_q, ready_q;

    logic            x_ge_s, mag_eq_s;
    logic [W:0]      dmp_s, dml_s;
    logic [EW-1:0]   exp_diff_s, shift_s;
    logic            real_op_s, zero_s, sign_s;

    // Next-state decode: beg only matters in IDLE, ack only in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beg_i) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD:  state_d = S_CMP;
            S_CMP:   state_d = S_SWAP;
            S_SWAP:  state_d = S_DONE;
            S_DONE: begin
                if (ack_i) state_d = S_IDLE;
                else       state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Swap-stage datapath: ordering, exponent difference, effective op and sign.
    always_comb begin
        x_ge_s     = (x_q[W-1:0] >= y_q[W-1:0]);
        mag_eq_s   = (x_q[W-1:0] == y_q[W-1:0]);
        dmp_s      = select_q ? x_q : y_q;
        dml_s      = select_q ? y_q : x_q;
        // select_q guarantees DMP exponent >= DmP exponent, so no underflow.
        exp_diff_s = dmp_s[W-1:SW] - dml_s[W-1:SW];
`ifdef FPU_SHIFT_SAT_EN
        // Beyond SW+2 the lesser operand only feeds the sticky bit.
        if (exp_diff_s > SAT_LIM) shift_s = SAT_LIM;
        else                      shift_s = exp_diff_s;
`else
        shift_s    = exp_diff_s;
`endif
        real_op_s  = x_q[W] ^ y_q[W] ^ op_q;
        zero_s     = mag_eq_s & real_op_s;
        // Exact cancellation yields +0; otherwise the DMP's effective sign.
        if (zero_s)        sign_s = 1'b0;
        else if (select_q) sign_s = x_q[W];
        else               sign_s = y_q[W] ^ op_q;
    end

    // State register plus registered busy/ready flags derived from next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_DONE);
        end
    end

    // Operand capture on an accepted start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q  <= '0;
            y_q  <= '0;
            op_q <= 1'b0;
        end else if (state_q == S_IDLE && beg_i) begin
            x_q  <= Data_X_i;
            y_q  <= Data_Y_i;
            op_q <= add_subt_i;
        end
    end

    // Magnitude compare result; ties favour X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            select_q <= 1'b0;
        end else if (state_q == S_CMP) begin
            select_q <= x_ge_s;
        end
    end

    // Result registers, loaded once in SWAP and held until the next SWAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmp_q     <= '0;
            dml_q     <= '0;
            shift_q   <= '0;
            real_op_q <= 1'b0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else if (state_q == S_SWAP) begin
            dmp_q     <= dmp_s;
            dml_q     <= dml_s;
            shift_q   <= shift_s;
            real_op_q <= real_op_s;
            sign_q    <= sign_s;
            zero_q    <= zero_s;
        end
    end

    assign busy_o       = busy_q;
    assign ready_o      = ready_q;
    assign select_o     = select_q;
    assign DMP_o        = dmp_q;
    assign DmP_o        = dml_q;
    assign shift_amt_o  = shift_q;
    assign real_op_o    = real_op_q;
    assign sign_final_o = sign_q;
    assign zero_o       = zero_q;

endmodule

// File: tb/tb_fpu_swap_ctrl.sv
// Scoreboard bench for fpu_swap_ctrl (single-precision build).
module tb_fpu_swap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        beg = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] data_x = 32'd0;
    logic [31:0] data_y = 32'd0;
    logic        add_subt = 1'b0;
    logic        busy_o, ready_o, select_o, real_op_o, sign_final_o, zero_o;
    logic [31:0] DMP_o, DmP_o;
    logic [7:0]  shift_amt_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sel;
        logic [31:0] dmp;
        logic [31:0] dml;
        logic [7:0]  sh;
        logic        rop;
        logic        sgn;
        logic        zero;
    } exp_t;

    exp_t sb[$];

    fpu_swap_ctrl #(.EW(8), .SW(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .beg_i        (beg),
        .ack_i        (ack),
        .Data_X_i     (data_x),
        .Data_Y_i     (data_y),
        .add_subt_i   (add_subt),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .select_o     (select_o),
        .DMP_o        (DMP_o),
        .DmP_o        (DmP_o),
        .shift_amt_o  (shift_amt_o),
        .real_op_o    (real_op_o),
        .sign_final_o (sign_final_o),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: order by magnitude, subtract exponents, resolve effective sign.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
        exp_t        e;
        int unsigned mx, my;
        int          ex, ey, d;
        logic        ys;
        mx = {1'b0, x[30:0]};
        my = {1'b0, y[30:0]};
        ex = int'({24'd0, x[30:23]});
        ey = int'({24'd0, y[30:23]});
        ys = y[31] ^ op;
        e.sel = (mx >= my);
        if (e.sel) begin
            e.dmp = x; e.dml = y; d = ex - ey;
        end else begin
            e.dmp = y; e.dml = x; d = ey - ex;
        end
`ifdef FPU_SHIFT_SAT_EN
        if (d > 25) d = 25;
`endif
        e.sh   = 8'(d);
        e.rop  = (x[31] != ys);
        e.zero = (mx == my) && e.rop;
        e.sgn  = e.zero ? 1'b0 : (e.sel ? x[31] : ys);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_select"}, 32'(select_o), 32'(e.sel));
        check({tag, "_DMP"}, DMP_o, e.dmp);
        check({tag, "_DmP"}, DmP_o, e.dml);
        check({tag, "_shift"}, 32'(shift_amt_o), 32'(e.sh));
        check({tag, "_real_op"}, 32'(real_op_o), 32'(e.rop));
        check({tag, "_sign"}, 32'(sign_final_o), 32'(e.sgn));
        check({tag, "_zero"}, 32'(zero_o), 32'(e.zero));
    endtask

    // Monitor: on every rising ready, pop the oldest expectation and compare.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_o && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'(ready_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_result("mon", e);
                end
            end
            prev = ready_o;
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic op,
                          input int hold, input bit noise_in_cmp, input bit beg_with_ack);
        exp_t e;
        e = model(x, y, op);
        @(negedge clk);
        data_x = x; data_y = y; add_subt = op; beg = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        beg = 1'b0;
        data_x = $urandom; data_y = $urandom; add_subt = 1'($urandom_range(0, 1));
        check("busy_after_beg", 32'(busy_o), 32'd1);
        check("ready_early", 32'(ready_o), 32'd0);
        @(negedge clk);
        if (noise_in_cmp) begin
            beg = 1'b1; ack = 1'b1;
        end
        @(negedge clk);
        beg = 1'b0; ack = 1'b0;
        check("select_latency", 32'(select_o), 32'(e.sel));
        check("ready_not_yet", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("ready_latency", 32'(ready_o), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ready_held", 32'(ready_o), 32'd1);
            check_result("hold", e);
        end
        ack = 1'b1; beg = beg_with_ack;
        @(negedge clk);
        ack = 1'b0; beg = 1'b0;
        check("ready_after_ack", 32'(ready_o), 32'd0);
        check("busy_after_ack", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("idle_after_ack", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rx, ry;
        int          kind;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_select", 32'(select_o), 32'd0);
        check("rst_DMP", DMP_o, 32'd0);
        check("rst_DmP", DmP_o, 32'd0);
        check("rst_shift", 32'(shift_amt_o), 32'd0);
        check("rst_flags", {29'd0, real_op_o, sign_final_o, zero_o}, 32'd0);
        rst = 1'b1;

        // Directed cases, including a long DONE hold and beg+ack together.
        run_op(32'h40400000, 32'h3F800000, 1'b0, 5, 1'b1, 1'b1);
        run_op(32'h3F800000, 32'h40400000, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'hC0000000, 32'hC0000000, 1'b1, 1, 1'b0, 1'b0);
        run_op(32'h4F800000, 32'h3F800000, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h3F800000, 32'h4F800000, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'h7F800000, 32'h00000001, 1'b0, 0, 1'b0, 1'b0);

        // Reset while in CMP aborts and clears everything.
        @(negedge clk);
        data_x = 32'h41200000; data_y = 32'h3F000000; add_subt = 1'b1; beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd0);
        check("abort_select", 32'(select_o), 32'd0);
        check("abort_DMP", DMP_o, 32'd0);
        check("abort_DmP", DmP_o, 32'd0);
        check("abort_shift", 32'(shift_amt_o), 32'd0);
        check("abort_flags", {29'd0, real_op_o, sign_final_o, zero_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_abort_ready", 32'(ready_o), 32'd0);
            check("post_abort_busy", 32'(busy_o), 32'd0);
        end

        // Randomized operations with random hold time and ignored noise.
        for (int n = 0; n < 40; n++) begin
            rx = $urandom;
            ry = $urandom;
            kind = $urandom_range(0, 3);
            if (kind == 0) ry = {1'($urandom_range(0, 1)), rx[30:0]};
            else if (kind == 1) ry = {ry[31], rx[30:23], ry[22:0]};
            run_op(rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
